// File: rtl/kf_pkg.sv
// ============================================================================
// Module     : kf_pkg
// Description: Shared width default and sequencer state encoding for kf blocks.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package kf_pkg;

  localparam int KF_WIDTH = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL1 = 3'd1;
  localparam logic [2:0] ST_MUL2 = 3'd2;
  localparam logic [2:0] ST_ADD  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    MUL1 = ST_MUL1,
    MUL2 = ST_MUL2,
    ADD  = ST_ADD,
    DONE = ST_DONE
  } kf_state_e;

endpackage

`default_nettype wire

// File: rtl/kf_add.sv
// ============================================================================
// Module     : kf_add
// Description: Shared unsigned adder cell; carry-out returned in the MSB.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module kf_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   s
);

  assign s = {1'b0, a} + {1'b0, b};

endmodule

`default_nettype wire

// File: rtl/kf_mult.sv
// ============================================================================
// Module     : kf_mult
// Description: Shared unsigned multiplier cell with full double-width product.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module kf_mult #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

`default_nettype wire

// File: rtl/kf_mac_sequencer.sv
// ============================================================================
// Module     : kf_mac_sequencer
// Description: Computes a*b*c+d on one shared multiplier and one shared adder,
//              one operation per cycle, behind valid/ready handshakes.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module kf_mac_sequencer
  import kf_pkg::*;
#(
  parameter int WIDTH = KF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             busy
);

  kf_state_e          r_state;
  logic [WIDTH-1:0]   r_a, r_b, r_c, r_d, r_prod, r_out;
  logic               r_ovf_acc, r_ovf, r_out_valid;

  logic [WIDTH-1:0]   w_mul_a, w_mul_b, w_add_a, w_add_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_sum;
  logic               w_accept, w_take;

  assign in_ready  = ((r_state == IDLE) | ((r_state == DONE) & out_ready)) & ~clear;
  assign w_accept  = in_valid & in_ready;
  assign w_take    = r_out_valid & out_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign ovf       = r_ovf;
  assign busy      = (r_state != IDLE);

  // Units see zero operands outside their slot so they idle quietly.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      MUL1: begin w_mul_a = r_a;    w_mul_b = r_b; end
      MUL2: begin w_mul_a = r_prod; w_mul_b = r_c; end
      default: ;
    endcase
  end

  assign w_add_a = (r_state == ADD) ? r_prod : '0;
  assign w_add_b = (r_state == ADD) ? r_d    : '0;

  kf_mult #(.WIDTH(WIDTH)) u_mult (.a(w_mul_a), .b(w_mul_b), .p(w_prod));
  kf_add  #(.WIDTH(WIDTH)) u_add  (.a(w_add_a), .b(w_add_b), .s(w_sum));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_prod      <= '0;
      r_out       <= '0;
      r_ovf_acc   <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_c       <= c;
            r_d       <= d;
            r_ovf_acc <= 1'b0;
            r_state   <= MUL1;
          end
        end
        MUL1: begin
          r_prod    <= w_prod[WIDTH-1:0];
          r_ovf_acc <= r_ovf_acc | (|w_prod[2*WIDTH-1:WIDTH]);
          r_state   <= MUL2;
        end
        MUL2: begin
          r_prod    <= w_prod[WIDTH-1:0];
          r_ovf_acc <= r_ovf_acc | (|w_prod[2*WIDTH-1:WIDTH]);
          r_state   <= ADD;
        end
        ADD: begin
          r_out       <= w_sum[WIDTH-1:0];
          r_ovf       <= r_ovf_acc | w_sum[WIDTH];
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (w_take) begin
            r_out_valid <= 1'b0;
            // A take may overlap the next accept to keep 4-cycle throughput.
            if (w_accept) begin
              r_a       <= a;
              r_b       <= b;
              r_c       <= c;
              r_d       <= d;
              r_ovf_acc <= 1'b0;
              r_state   <= MUL1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kf_mac_sequencer.sv
// ============================================================================
// Module     : tb_kf_mac_sequencer
// Description: Self-checking bench for kf_mac_sequencer against an arithmetic model.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_kf_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0, c = '0, d = '0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        ovf;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  kf_mac_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected {ovf, out}: overflow if any stage of a*b, (ab)*c, +d spills past 32 bits.
  function automatic logic [32:0] model(input logic [31:0] ma, mb, mc, md);
    logic [63:0] p1, p2;
    logic [32:0] s;
    p1 = {32'd0, ma} * {32'd0, mb};
    p2 = {32'd0, p1[31:0]} * {32'd0, mc};
    s  = {1'b0, p2[31:0]} + {1'b0, md};
    return {(p1[63:32] != 0) || (p2[63:32] != 0) || s[32], s[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle.
  task automatic run_req(input logic [31:0] ra, rb, rc, rd, input int stall, input string tag);
    logic [32:0] e;
    int cyc;
    e = model(ra, rb, rc, rd);
    out_ready = (stall == 0);
    in_valid = 1'b1;
    a = ra; b = rb; c = rc; d = rd;
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 12) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 3);
    chk({tag, "_out"}, out, e[31:0]);
    chk({tag, "_ovf"}, ovf, e[32]);
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_out"}, out, e[31:0]);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk({tag, "_take_in_ready"}, in_ready, 1);
    @(posedge clk); @(negedge clk);
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_busy"}, busy, 0);
    chk({tag, "_post_out_kept"}, out, e[31:0]);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [32:0] e;
    logic [31:0] ra, rb, rc, rd;
    int cyc;

    // Reset state while rst is held
    #2;
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);

    run_req(32'd2, 32'd3, 32'd4, 32'd5, 0, "basic");
    run_req(32'd2, 32'd3, 32'd4, 32'd5, 4, "stall");
    run_req(32'h10000, 32'h10000, 32'd1, 32'd1, 0, "mul_ovf");
    run_req(32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 0, "add_ovf");

    // Back-to-back with in_valid held; operand change mid-flight must be ignored
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 2; b = 3; c = 4; d = 5;
    @(posedge clk); @(negedge clk);
    a = 1; b = 1; c = 1; d = 0;
    cyc = 0;
    while (!out_valid && cyc < 12) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    chk("b2b_first_latency", cyc, 3);
    chk("b2b_first_out", out, 29);
    #1 chk("b2b_in_ready_on_take", in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_busy_after_take", busy, 1);
    cyc = 0;
    while (!out_valid && cyc < 12) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    chk("b2b_second_gap", cyc, 3);
    chk("b2b_second_out", out, 1);
    chk("b2b_second_ovf", ovf, 0);
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", busy, 0);

    // clear while in MUL2
    in_valid = 1'b1;
    a = 9; b = 9; c = 9; d = 9;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    clear = 1'b1;
    #1 chk("clr_in_ready", in_ready, 0);
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    chk("clr_busy", busy, 0);
    out_ready = 1'b1;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) cyc++;
      @(posedge clk); @(negedge clk);
    end
    chk("clr_no_result", cyc, 0);
    run_req(32'd7, 32'd8, 32'd9, 32'd10, 0, "after_clr");

    // Async reset between edges while in ADD
    in_valid = 1'b1;
    a = 3; b = 3; c = 3; d = 3;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_out", out, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) cyc++;
      @(posedge clk); @(negedge clk);
    end
    chk("arst_no_result", cyc, 0);

    // Randomized requests with random consumer stalls
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: begin ra = $urandom_range(0, 255); rb = $urandom_range(0, 255);
                 rc = $urandom_range(0, 255); rd = $urandom_range(0, 255); end
        1: begin ra = $urandom_range(0, 65535); rb = $urandom_range(0, 65535);
                 rc = $urandom_range(0, 3); rd = $urandom; end
        default: begin ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom; end
      endcase
      run_req(ra, rb, rc, rd, $urandom_range(0, 3), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
